// File: rtl/xmem_stream_if.sv
// xmem_stream_if: bundles the write port, command port, output stream and
// status lines of xmem_stream_core.
//   master : fill/DMA + command source + stream consumer (testbench side)
//   slave  : xmem_stream_core
// Signals:
//   wr_en/wr_bank/wr_addr/wr_data -> bank write, wr_err <- dropped-write pulse
//   cmd_valid/cmd_bank/cmd_base/cmd_len/cmd_rep -> command, cmd_ready <- idle
//   out_valid/out_data/out_last <- stream word, out_ready -> consumer accept
//   busy/done <- sequencer status
interface xmem_stream_if #(
    parameter int bw  = 4,
    parameter int row = 8,
    parameter int aw  = 11,
    parameter int bkw = 1
) ();
    logic                wr_en;
    logic [bkw-1:0]      wr_bank;
    logic [aw-1:0]       wr_addr;
    logic [bw*row-1:0]   wr_data;
    logic                wr_err;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [bkw-1:0]      cmd_bank;
    logic [aw-1:0]       cmd_base;
    logic [aw:0]         cmd_len;
    logic [7:0]          cmd_rep;

    logic                out_valid;
    logic                out_ready;
    logic [bw*row-1:0]   out_data;
    logic                out_last;

    logic                busy;
    logic                done;

    modport master (
        output wr_en, wr_bank, wr_addr, wr_data,
        output cmd_valid, cmd_bank, cmd_base, cmd_len, cmd_rep,
        output out_ready,
        input  wr_err, cmd_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  wr_en, wr_bank, wr_addr, wr_data,
        input  cmd_valid, cmd_bank, cmd_base, cmd_len, cmd_rep,
        input  out_ready,
        output wr_err, cmd_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/xmem_stream_core.sv
// xmem_stream_core: nbank input-memory banks of bw*row-bit words. A command
// streams an address window (wrapping modulo depth), repeated rep times, out
// of one bank through a 2-entry skid FIFO. Writes to non-active banks proceed
// in parallel; writes to the active bank while busy are dropped (wr_err).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : xmem_stream_if slave (write, command, stream and status signals)
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// RUN   | issuing bank reads, one per cycle while the FIFO has room
// DRAIN | all reads issued, waiting for FIFO and read pipe to empty
// DONE  | one-cycle done pulse
module xmem_stream_core #(
    parameter int bw    = 4,
    parameter int row   = 8,
    parameter int depth = 2048,
    parameter int nbank = 2,
    parameter int aw    = $clog2(depth),
    parameter int bkw   = $clog2(nbank)
) (
    input  logic          clk,
    input  logic          reset,
    xmem_stream_if.slave  bus
);
    localparam int w = bw * row;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state, state_nxt;

    logic [w-1:0]   mem [nbank][depth];

    logic [bkw-1:0] act_bank;
    logic [aw-1:0]  ptr, base_q;
    logic [aw:0]    cnt, len_q;
    logic [7:0]     pass;

    logic [w-1:0]   rd_data;
    logic           inflight, rd_last;

    logic [w-1:0]   fifo_data [2];
    logic [1:0]     fifo_last;
    logic           fifo_wr, fifo_rd;
    logic [1:0]     fifo_cnt;

    logic           cmd_acc, rd_issue, pop, last_rd, wr_block, wr_err_q;
    logic [2:0]     occ_nxt;

    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_data  = fifo_data[fifo_rd];
    assign bus.out_last  = fifo_last[fifo_rd];
    assign bus.wr_err    = wr_err_q;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        rd_issue      = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        cmd_acc       = 1'b0;
        pop           = bus.out_valid && bus.out_ready;
        // Occupancy (FIFO + read pipe) after this edge if nothing new is
        // issued. Counting the pop here is what keeps the stream bubble-free.
        occ_nxt       = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
        last_rd       = (cnt == (aw+1)'(1)) && (pass <= 8'd1);
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    cmd_acc   = 1'b1;
                    state_nxt = (bus.cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (occ_nxt < 3'd2) begin
                    rd_issue = 1'b1;
                    if (last_rd) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (!inflight && occ_nxt == 3'd0) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window sequencer: ptr walks the window, cnt counts down words left in
    // the pass, pass counts down remaining passes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            act_bank <= '0;
            ptr      <= '0;
            base_q   <= '0;
            cnt      <= '0;
            len_q    <= '0;
            pass     <= '0;
        end else if (cmd_acc) begin
            act_bank <= bus.cmd_bank;
            ptr      <= bus.cmd_base;
            base_q   <= bus.cmd_base;
            cnt      <= bus.cmd_len;
            len_q    <= bus.cmd_len;
            pass     <= (bus.cmd_rep == 8'd0) ? 8'd1 : bus.cmd_rep;
        end else if (rd_issue) begin
            if (cnt == (aw+1)'(1)) begin
                if (pass > 8'd1) begin
                    ptr  <= base_q;
                    cnt  <= len_q;
                    pass <= pass - 8'd1;
                end else begin
                    cnt  <= '0;
                end
            end else begin
                ptr <= ptr + 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign wr_block = bus.busy && (bus.wr_bank == act_bank);

    // Bank storage is never reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !wr_block) mem[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_issue) rd_data <= mem[act_bank][ptr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight <= 1'b0;
            rd_last  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            inflight <= rd_issue;
            rd_last  <= rd_issue && last_rd;
            wr_err_q <= bus.wr_en && wr_block;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            fifo_wr      <= 1'b0;
            fifo_rd      <= 1'b0;
            fifo_cnt     <= '0;
        end else begin
            if (inflight) begin
                fifo_data[fifo_wr] <= rd_data;
                fifo_last[fifo_wr] <= rd_last;
                fifo_wr            <= ~fifo_wr;
            end
            if (pop) fifo_rd <= ~fifo_rd;
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_xmem_stream_core.sv
module tb_xmem_stream_core;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    xmem_stream_if #(.bw(4), .row(8), .aw(11), .bkw(1)) bus ();

    xmem_stream_core #(.bw(4), .row(8), .depth(DEPTH), .nbank(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [2][DEPTH];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({pfx, "_out_valid"}, bus.out_valid, 0);
        chk({pfx, "_out_last"},  bus.out_last,  0);
        chk({pfx, "_busy"},      bus.busy,      0);
        chk({pfx, "_done"},      bus.done,      0);
        chk({pfx, "_wr_err"},    bus.wr_err,    0);
        chk({pfx, "_out_data"},  bus.out_data,  0);
    endtask

    task automatic wr(input int bank, input int addr, input logic [31:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_bank = 1'(bank);
        bus.wr_addr = 11'(addr);
        bus.wr_data = data;
        model[bank][addr] = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic fill_bank(input int bank);
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            bus.wr_en   = 1'b1;
            bus.wr_bank = 1'(bank);
            bus.wr_addr = 11'(a);
            bus.wr_data = $urandom;
            model[bank][a] = bus.wr_data;
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Drives one command and consumes its stream. rnd_rdy toggles out_ready
    // at random; abort_after > 0 pulses reset after that many words.
    task automatic run_cmd(input int bank, input int base, input int len, input int rep,
                           input bit rnd_rdy, input int abort_after);
        int eff_rep, nwords, first_v, first_pop, last_pop, done_j, pops, budget;
        bit saw_valid, late_done;
        exp_t e;
        eff_rep = (rep == 0) ? 1 : rep;
        nwords  = len * eff_rep;
        for (int p = 0; p < eff_rep; p++)
            for (int i = 0; i < len; i++) begin
                e.data = model[bank][(base + i) % DEPTH];
                e.last = (p == eff_rep - 1) && (i == len - 1);
                sb.push_back(e);
            end
        first_v = -1; first_pop = -1; last_pop = -1; done_j = -1; pops = 0;
        saw_valid = 1'b0;
        budget = 2 * nwords + 64;

        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_bank  = 1'(bank);
        bus.cmd_base  = 11'(base);
        bus.cmd_len   = 12'(len);
        bus.cmd_rep   = 8'(rep);
        bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);

        for (int j = 0; j < budget; j++) begin
            @(negedge clk);
            if (j == 0) bus.cmd_valid = 1'b0;
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid) begin
                saw_valid = 1'b1;
                if (first_v < 0) first_v = j;
                if (sb.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    chk("out_data", bus.out_data, sb[0].data);
                    chk("out_last", bus.out_last, sb[0].last);
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        pops++;
                        if (first_pop < 0) first_pop = j;
                        last_pop = j;
                        if (abort_after > 0 && pops == abort_after) begin
                            reset = 1'b0;
                            @(negedge clk);
                            reset = 1'b1;
                            chk_reset_vals("abort");
                            sb.delete();
                            late_done = 1'b0;
                            for (int k = 0; k < 6; k++) begin
                                @(negedge clk);
                                if (bus.done || bus.out_valid) late_done = 1'b1;
                            end
                            chk("abort_no_done", late_done, 0);
                            chk("abort_cmd_ready", bus.cmd_ready, 1);
                            return;
                        end
                    end
                end
            end
            if (bus.done) begin
                done_j = j;
                chk("busy_at_done", bus.busy, 0);
                chk("cmd_ready_at_done", bus.cmd_ready, 0);
                break;
            end
        end

        chk("done_seen", (done_j >= 0), 1);
        chk("all_words", sb.size(), 0);
        if (len == 0) begin
            chk("zero_len_no_valid", saw_valid, 0);
        end else if (!rnd_rdy) begin
            chk("first_latency", first_v, 2);
            chk("no_bubbles", last_pop - first_pop, nwords - 1);
            chk("done_after_last", done_j, last_pop + 1);
        end
        sb.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_done", bus.cmd_ready, 1);
        chk("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_bank = '0; bus.cmd_base = '0;
        bus.cmd_len = '0; bus.cmd_rep = '0; bus.out_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;

        fill_bank(0);
        fill_bank(1);
        for (int i = 0; i < 8; i++) wr(0, i, 32'h1111_1111 * (i + 1));

        run_cmd(0, 0, 8, 1, 1'b0, 0);
        run_cmd(1, 2046, 4, 0, 1'b0, 0);
        run_cmd(0, 10, 3, 3, 1'b0, 0);
        run_cmd(1, 300, 16, 1, 1'b1, 0);

        fork
            run_cmd(0, 0, 16, 1, 1'b0, 0);
            begin
                repeat (4) @(negedge clk);
                bus.wr_en = 1'b1; bus.wr_bank = 1'b0; bus.wr_addr = 11'd5;
                bus.wr_data = 32'hDEAD_BEEF;
                @(negedge clk);
                chk("wr_err_active_bank", bus.wr_err, 1);
                bus.wr_bank = 1'b1; bus.wr_data = 32'hCAFE_F00D;
                model[1][5] = 32'hCAFE_F00D;
                @(negedge clk);
                chk("wr_err_other_bank", bus.wr_err, 0);
                bus.wr_en = 1'b0;
            end
        join
        run_cmd(0, 5, 1, 1, 1'b0, 0);
        run_cmd(1, 5, 1, 1, 1'b0, 0);

        run_cmd(0, 0, 8, 1, 1'b0, 4);
        run_cmd(0, 0, 8, 1, 1'b0, 0);

        run_cmd(1, 0, 0, 5, 1'b0, 0);
        run_cmd(0, 1000, DEPTH, 1, 1'b0, 0);
        run_cmd(1, 2040, 5, 4, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
